rail_stack_checker: RTL and testbench

- Parametrised station-rail permutation checker. Cars 1..N arrive in ascending order and may wait on a dead-end siding (a LIFO) of runtime-limited capacity.
- The block decides whether a requested departure order is achievable. It reports pass/fail, the first failing position and the peak siding occupancy.
- It is a standalone compute block with a beat-serial input and a single-pulse result output. It generalises the fixed 10-car checker to MAX_N cars, a capacity limit and diagnostic outputs.

---
 rtl/rail_pkg.sv | 16 +
 rtl/rail_lifo.sv | 73 +++++++
 rtl/rail_stack_checker.sv | 170 +++++++++++++++++
 tb/tb_rail_stack_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rail_pkg.sv
// Shared types and width helpers for the station-rail permutation checker.
package rail_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } rail_state_t;

    // Bits needed to hold any value in 0..max_n.
    function automatic int rail_dw(input int max_n);
        return $clog2(max_n + 1);
    endfunction

endpackage

// File: rtl/rail_lifo.sv
// Siding model: a LIFO of DEPTH car numbers with a combinational view of the top entry.
module rail_lifo
    import rail_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int W     = rail_dw(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic [W-1:0] sp,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [W-1:0]     sp_reg;
    logic [W-1:0]     sp_next;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] wr_sel;

    assign full    = (sp_reg == W'(DEPTH));
    assign empty   = (sp_reg == '0);
    assign sp      = sp_reg;
    // Pop takes priority when both are requested in the same cycle.
    assign do_pop  = !clear && pop && !empty;
    assign do_push = !clear && push && !pop && !full;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = do_push && (sp_reg == W'(gi));
        end
    endgenerate

    always_comb begin
        sp_next = sp_reg;
        if (clear)
            sp_next = '0;
        else if (do_pop)
            sp_next = sp_reg - W'(1);
        else if (do_push)
            sp_next = sp_reg + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sp_reg <= '0;
        else
            sp_reg <= sp_next;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i])
                mem[i] <= push_data;
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_reg == W'(i + 1))
                top = mem[i];
        end
    end

endmodule

// File: rtl/rail_stack_checker.sv
// Decides whether a requested departure order of cars 1..N is reachable through a
// capacity-limited siding; reports pass/fail, first failing position and peak occupancy.
module rail_stack_checker
    import rail_pkg::*;
#(
    parameter  int MAX_N = 15,
    localparam int DW    = rail_dw(MAX_N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] cap,
    output logic          busy,
    output logic          out_valid,
    output logic          result,
    output logic [DW-1:0] fail_pos,
    output logic [DW-1:0] peak_depth
);

    rail_state_t   state_reg;
    logic [DW-1:0] n_reg;
    logic [DW-1:0] cap_reg;
    logic [DW-1:0] cnt_reg;
    logic [DW-1:0] idx_reg;
    // One bit wider than DW: after car N is pushed it holds N+1, which may be 2^DW.
    logic [DW:0]   next_reg;
    logic [DW-1:0] run_peak_reg;
    logic          result_reg;
    logic [DW-1:0] fail_pos_reg;
    logic [DW-1:0] peak_reg;

    logic [DW-1:0] req [MAX_N];
    logic [DW-1:0] req_cur;
    logic [DW-1:0] n_clamp;
    logic [DW-1:0] cap_eff;
    logic [MAX_N-1:0] req_we;
    logic          load_beat;

    logic [DW-1:0] lifo_top;
    logic [DW-1:0] lifo_sp;
    logic          lifo_full;
    logic          lifo_empty;
    logic          lifo_clear;
    logic          can_pop;
    logic          can_push;
    logic          do_pop;
    logic          do_push;

    assign n_clamp    = (in_data > DW'(MAX_N)) ? DW'(MAX_N) : in_data;
    assign cap_eff    = (cap == '0 || cap > DW'(MAX_N)) ? DW'(MAX_N) : cap;
    assign load_beat  = (state_reg == LOAD) && in_valid;
    assign lifo_clear = (state_reg == IDLE) && in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_N; gi++) begin : g_req_we
            assign req_we[gi] = load_beat && (cnt_reg == DW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_N; i++) begin
            if (req_we[i])
                req[i] <= in_data;
        end
    end

    always_comb begin
        req_cur = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (idx_reg == DW'(i))
                req_cur = req[i];
        end
    end

    assign can_pop  = !lifo_empty && (lifo_top == req_cur);
    assign can_push = (next_reg <= {1'b0, req_cur}) && (next_reg <= {1'b0, n_reg})
                      && !lifo_full && (lifo_sp < cap_reg);
    assign do_pop   = (state_reg == RUN) && can_pop;
    assign do_push  = (state_reg == RUN) && !can_pop && can_push;

    rail_lifo #(
        .DEPTH (MAX_N),
        .W     (DW)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (lifo_clear),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (next_reg[DW-1:0]),
        .top       (lifo_top),
        .sp        (lifo_sp),
        .full      (lifo_full),
        .empty     (lifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            n_reg        <= '0;
            cap_reg      <= '0;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            next_reg     <= '0;
            run_peak_reg <= '0;
            result_reg   <= 1'b0;
            fail_pos_reg <= '0;
            peak_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    n_reg        <= n_clamp;
                    cap_reg      <= cap_eff;
                    cnt_reg      <= '0;
                    idx_reg      <= '0;
                    next_reg     <= (DW+1)'(1);
                    run_peak_reg <= '0;
                    if (n_clamp == '0) begin
                        state_reg    <= DONE;
                        result_reg   <= 1'b1;
                        fail_pos_reg <= '0;
                        peak_reg     <= '0;
                    end else begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: if (in_valid) begin
                    cnt_reg <= cnt_reg + DW'(1);
                    if (cnt_reg + DW'(1) == n_reg)
                        state_reg <= RUN;
                end else begin
                    // Stream ended short: the first missing request is the failure point.
                    state_reg    <= DONE;
                    result_reg   <= 1'b0;
                    fail_pos_reg <= cnt_reg;
                    peak_reg     <= '0;
                end
                RUN: if (do_pop) begin
                    idx_reg <= idx_reg + DW'(1);
                    if (idx_reg + DW'(1) == n_reg) begin
                        state_reg    <= DONE;
                        result_reg   <= 1'b1;
                        fail_pos_reg <= '0;
                        peak_reg     <= run_peak_reg;
                    end
                end else if (do_push) begin
                    next_reg <= next_reg + (DW+1)'(1);
                    if (lifo_sp >= run_peak_reg)
                        run_peak_reg <= lifo_sp + DW'(1);
                end else begin
                    state_reg    <= DONE;
                    result_reg   <= 1'b0;
                    fail_pos_reg <= idx_reg;
                    peak_reg     <= run_peak_reg;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign out_valid  = (state_reg == DONE);
    assign result     = result_reg;
    assign fail_pos   = fail_pos_reg;
    assign peak_depth = peak_reg;

endmodule

// File: tb/tb_rail_stack_checker.sv
// Scoreboard bench: a reference model predicts each evaluation when it is driven,
// and a negedge monitor compares every out_valid strobe against the queued prediction.
module tb_rail_stack_checker;

    localparam int MAX_N = 12;
    localparam int DW    = $clog2(MAX_N + 1);

    typedef struct {
        int res;
        int fp;
        int pk;
        int lim;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [DW-1:0] cap;
    logic          busy;
    logic          out_valid;
    logic          result;
    logic [DW-1:0] fail_pos;
    logic [DW-1:0] peak_depth;

    int   checks_cnt = 0;
    int   errors_cnt = 0;
    int   done_cnt   = 0;
    int   cycle_cnt  = 0;
    int   last_accept_cyc = 0;
    int   txn_cnt    = 0;
    logic prev_ov    = 1'b0;
    exp_t exp_q[$];

    rail_stack_checker #(.MAX_N(MAX_N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .cap        (cap),
        .busy       (busy),
        .out_valid  (out_valid),
        .result     (result),
        .fail_pos   (fail_pos),
        .peak_depth (peak_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check_val(input string tag, input int got, input int expv);
        checks_cnt++;
        if (got !== expv) begin
            errors_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    // Reference: the siding algorithm applied to the order as a plain queue.
    function automatic void model(input int n, input int capv, input int ord[$], input int nsend,
                                  output int res, output int fp, output int pk);
        int nc, ce, recv, nxt, idx;
        int st[$];
        nc   = (n > MAX_N) ? MAX_N : n;
        ce   = (capv == 0 || capv > MAX_N) ? MAX_N : capv;
        recv = (nsend < nc) ? nsend : nc;
        res = 0; fp = 0; pk = 0;
        if (nc == 0) begin res = 1; return; end
        if (recv < nc) begin fp = recv; return; end
        nxt = 1; idx = 0;
        forever begin
            if (idx == nc) begin res = 1; fp = 0; return; end
            if (st.size() > 0 && st[st.size()-1] == ord[idx]) begin
                void'(st.pop_back());
                idx++;
            end else if (nxt <= ord[idx] && nxt <= nc && st.size() < ce) begin
                st.push_back(nxt);
                nxt++;
                if (st.size() > pk) pk = st.size();
            end else begin
                fp = idx;
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (prev_ov) begin
            check_val("ov_pulse", int'(out_valid), 0);
            check_val("busy_release", int'(busy), 0);
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_ov", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("result", int'(result), e.res);
                check_val("fail_pos", int'(fail_pos), e.fp);
                check_val("peak_depth", int'(peak_depth), e.pk);
                check_val("busy_in_done", int'(busy), 1);
                check_val("latency", int'((cycle_cnt - last_accept_cyc) <= e.lim), 1);
                txn_cnt++;
                $display("txn %0d: result=%0d fail_pos=%0d peak_depth=%0d latency=%0d",
                         txn_cnt, result, fail_pos, peak_depth, cycle_cnt - last_accept_cyc);
            end
            done_cnt <= done_cnt + 1;
        end
        prev_ov <= out_valid;
    end

    task automatic send(input int n, input int capv, input int ord[$], input int nsend);
        exp_t e;
        int   r, f, p, nc, start;
        bit   seen;
        model(n, capv, ord, nsend, r, f, p);
        nc = (n > MAX_N) ? MAX_N : n;
        e.res = r; e.fp = f; e.pk = p; e.lim = 2 * nc + 2;
        exp_q.push_back(e);
        start = done_cnt;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = DW'(n);
        cap      = DW'(capv);
        last_accept_cyc = cycle_cnt + 1;
        for (int i = 0; i < nsend; i++) begin
            @(posedge clk); #1;
            in_data = DW'(ord[i]);
            if (i < nc) last_accept_cyc = cycle_cnt + 1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        seen = (done_cnt != start);
        for (int c = 0; c < 4 * MAX_N + 20 && !seen; c++) begin
            @(negedge clk); #1;
            if (done_cnt != start) seen = 1'b1;
        end
        if (!seen) begin
            check_val("timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int ord[$];
        int start, j, t, nr;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cap = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_result", int'(result), 0);
        check_val("rst_fail_pos", int'(fail_pos), 0);
        check_val("rst_peak", int'(peak_depth), 0);

        send(5, 0, '{1, 2, 3, 4, 5}, 5);
        send(5, 0, '{5, 4, 3, 2, 1}, 5);
        send(5, 3, '{5, 4, 3, 2, 1}, 5);
        send(3, 0, '{3, 1, 2}, 3);
        send(4, 0, '{2, 2, 1, 3}, 4);
        send(3, 0, '{0, 1, 2}, 3);
        send(0, 0, '{0}, 0);
        send(6, 0, '{1, 2, 3, 4, 5, 6}, 3);
        send(14, 13, '{12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 13, 14}, 14);

        // Reset during RUN of a full-length evaluation: no strobe may follow.
        start = done_cnt;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = DW'(MAX_N); cap = '0;
        for (int i = 0; i < MAX_N; i++) begin
            @(posedge clk); #1;
            in_data = DW'(MAX_N - i);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4 * MAX_N) @(posedge clk);
        @(negedge clk);
        check_val("rst_mid_no_ov", done_cnt - start, 0);
        check_val("rst_mid_busy", int'(busy), 0);
        check_val("rst_mid_fail_pos", int'(fail_pos), 0);

        send(2, 0, '{2, 1}, 2);

        for (int k = 0; k < 10; k++) begin
            nr = $urandom_range(MAX_N, 1);
            ord = {};
            for (int i = 1; i <= nr; i++) ord.push_back(i);
            for (int i = nr - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            send(nr, $urandom_range(6, 0), ord, nr);
        end

        check_val("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
